// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory-side signals of the shared memory port.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if;
    logic        i_rd_en_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_data_o;
    logic        i_ack_o;
    logic        d_rd_en_i;
    logic        d_wr_en_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ack_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic        err_o;

    modport slave (
        input  i_rd_en_i, i_addr_i,
        input  d_rd_en_i, d_wr_en_i, d_addr_i, d_data_i,
        input  mem_data_i, mem_ack_i,
        output i_data_o, i_ack_o, d_data_o, d_ack_o,
        output mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        output err_o
    );

    modport master (
        output i_rd_en_i, i_addr_i,
        output d_rd_en_i, d_wr_en_i, d_addr_i, d_data_i,
        output mem_data_i, mem_ack_i,
        input  i_data_o, i_ack_o, d_data_o, d_ack_o,
        input  mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_data_o,
        input  err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word memory between fetch and load/store.
// One transaction at a time: IDLE -> ACCESS -> RESP, with optional ack timeout.
module mem_port_arbiter #(
    parameter bit USE_MEM_ACK = 1'b1,
    parameter int ACK_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic          gnt_d_q;
    logic          wr_q;
    logic          last_d_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   i_data_q;
    logic [31:0]   d_data_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;

    logic          i_req;
    logic          d_req;
    logic          pick_d;
    logic          done;
    logic          tmo;
    logic [31:0]   rdata;

    always_comb begin
        i_req   = bus.i_rd_en_i;
        d_req   = bus.d_rd_en_i | bus.d_wr_en_i;
        // on a tie the port that did not win last time goes first
        pick_d  = d_req & (~i_req | ~last_d_q);
        done    = 1'b0;
        tmo     = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_req | d_req) state_d = ACCESS;
            end
            ACCESS: begin
                done = !USE_MEM_ACK || bus.mem_ack_i;
                tmo  = USE_MEM_ACK && !bus.mem_ack_i &&
                       (cnt_q == CW'(ACK_TIMEOUT - 1));
                if (done || tmo) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rdata = done ? bus.mem_data_i : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_d_q  <= 1'b0;
            wr_q     <= 1'b0;
            last_d_q <= 1'b1;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            i_data_q <= 32'h0;
            d_data_q <= 32'h0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (i_req || d_req)) begin
                gnt_d_q  <= pick_d;
                wr_q     <= pick_d & bus.d_wr_en_i;
                addr_q   <= pick_d ? bus.d_addr_i : bus.i_addr_i;
                wdata_q  <= bus.d_data_i;
                last_d_q <= pick_d;
                cnt_q    <= '0;
            end else if (state_q == ACCESS) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if ((done || tmo) && !wr_q) begin
                if (gnt_d_q) d_data_q <= rdata;
                else         i_data_q <= rdata;
            end
            if (tmo) err_q <= 1'b1;
        end
    end

    logic in_acc;
    assign in_acc = (state_q == ACCESS);

    assign bus.mem_rd_en_o = in_acc & ~wr_q;
    assign bus.mem_wr_en_o = in_acc & wr_q;
    assign bus.mem_addr_o  = in_acc ? addr_q : 32'h0;
    assign bus.mem_data_o  = in_acc ? wdata_q : 32'h0;
    assign bus.i_ack_o     = (state_q == RESP) & ~gnt_d_q;
    assign bus.d_ack_o     = (state_q == RESP) & gnt_d_q;
    assign bus.i_data_o    = i_data_q;
    assign bus.d_data_o    = d_data_q;
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: u_dut0 completes immediately, u_dut1 waits for
// mem_ack_i with a 4-cycle timeout.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if b0();
    mem_port_arbiter_if b1();

    mem_port_arbiter #(.USE_MEM_ACK(1'b0), .ACK_TIMEOUT(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );
    mem_port_arbiter #(.USE_MEM_ACK(1'b1), .ACK_TIMEOUT(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    logic [31:0] mem0 [0:63];
    assign b0.mem_data_i = mem0[b0.mem_addr_o[7:2]];
    always @(posedge clk)
        if (b0.mem_wr_en_o) mem0[b0.mem_addr_o[7:2]] <= b0.mem_data_o;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem0[i] = 32'h0;
        mem0[2] = 32'h0050_0093;
        b0.i_rd_en_i = 0; b0.i_addr_i = 0; b0.mem_ack_i = 0;
        b0.d_rd_en_i = 0; b0.d_wr_en_i = 0;
        b0.d_addr_i = 0;  b0.d_data_i = 0;
        b1.i_rd_en_i = 0; b1.i_addr_i = 0;
        b1.d_rd_en_i = 0; b1.d_wr_en_i = 0;
        b1.d_addr_i = 0;  b1.d_data_i = 0;
        b1.mem_data_i = 0; b1.mem_ack_i = 0;

        repeat (2) tick();
        chk("rst_i_ack", 32'(b0.i_ack_o), 0);
        chk("rst_d_ack", 32'(b0.d_ack_o), 0);
        chk("rst_rd", 32'(b0.mem_rd_en_o), 0);
        chk("rst_wr", 32'(b0.mem_wr_en_o), 0);
        chk("rst_addr", b0.mem_addr_o, 0);
        chk("rst_i_data", b0.i_data_o, 0);
        chk("rst_err", 32'(b1.err_o), 0);
        rst_n = 1'b1;
        tick();

        // fetch only
        b0.i_rd_en_i = 1; b0.i_addr_i = 32'h8;
        tick();
        chk("f_rd", 32'(b0.mem_rd_en_o), 1);
        chk("f_addr", b0.mem_addr_o, 32'h8);
        chk("f_ack_early", 32'(b0.i_ack_o), 0);
        tick();
        chk("f_ack", 32'(b0.i_ack_o), 1);
        chk("f_rd_off", 32'(b0.mem_rd_en_o), 0);
        chk("f_data", b0.i_data_o, 32'h0050_0093);
        b0.i_rd_en_i = 0;
        tick();
        chk("f_ack_pulse", 32'(b0.i_ack_o), 0);

        // store then load
        b0.d_wr_en_i = 1; b0.d_addr_i = 32'h40; b0.d_data_i = 32'hCAFE_BABE;
        tick();
        chk("st_wr", 32'(b0.mem_wr_en_o), 1);
        chk("st_rd", 32'(b0.mem_rd_en_o), 0);
        chk("st_addr", b0.mem_addr_o, 32'h40);
        chk("st_wdata", b0.mem_data_o, 32'hCAFE_BABE);
        tick();
        chk("st_ack", 32'(b0.d_ack_o), 1);
        chk("st_i_ack", 32'(b0.i_ack_o), 0);
        chk("st_wr_off", 32'(b0.mem_wr_en_o), 0);
        b0.d_wr_en_i = 0;
        tick();
        b0.d_rd_en_i = 1;
        tick();
        chk("ld_rd", 32'(b0.mem_rd_en_o), 1);
        chk("ld_addr", b0.mem_addr_o, 32'h40);
        tick();
        chk("ld_ack", 32'(b0.d_ack_o), 1);
        chk("ld_i_ack", 32'(b0.i_ack_o), 0);
        chk("ld_data", b0.d_data_o, 32'hCAFE_BABE);
        chk("ld_i_hold", b0.i_data_o, 32'h0050_0093);
        b0.d_rd_en_i = 0;
        tick();

        // both ports requesting: I first, then alternating
        b0.i_rd_en_i = 1; b0.d_rd_en_i = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("rr_i_ack%0d", k), 32'(b0.i_ack_o),
                32'((k % 6) == 2));
            chk($sformatf("rr_d_ack%0d", k), 32'(b0.d_ack_o),
                32'((k % 6) == 5));
        end
        b0.i_rd_en_i = 0; b0.d_rd_en_i = 0;
        tick();

        // ack on third ACCESS cycle
        b1.mem_data_i = 32'h1111_2222;
        b1.i_rd_en_i = 1; b1.i_addr_i = 32'h10;
        tick();
        chk("ma_rd1", 32'(b1.mem_rd_en_o), 1);
        tick();
        chk("ma_rd2", 32'(b1.mem_rd_en_o), 1);
        tick();
        chk("ma_rd3", 32'(b1.mem_rd_en_o), 1);
        chk("ma_ack_early", 32'(b1.i_ack_o), 0);
        b1.mem_ack_i = 1;
        tick();
        b1.mem_ack_i = 0;
        chk("ma_ack", 32'(b1.i_ack_o), 1);
        chk("ma_data", b1.i_data_o, 32'h1111_2222);
        chk("ma_err", 32'(b1.err_o), 0);
        chk("ma_rd_off", 32'(b1.mem_rd_en_o), 0);
        b1.i_rd_en_i = 0;
        tick();

        // good load, then timed-out load
        b1.mem_data_i = 32'hDEAD_BEEF;
        b1.d_rd_en_i = 1; b1.d_addr_i = 32'h20;
        tick();
        b1.mem_ack_i = 1;
        tick();
        b1.mem_ack_i = 0;
        chk("gl_ack", 32'(b1.d_ack_o), 1);
        chk("gl_data", b1.d_data_o, 32'hDEAD_BEEF);
        b1.d_rd_en_i = 0;
        tick();
        b1.d_rd_en_i = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("to_rd%0d", k), 32'(b1.mem_rd_en_o), 1);
            chk($sformatf("to_ack%0d", k), 32'(b1.d_ack_o), 0);
        end
        tick();
        chk("to_ack", 32'(b1.d_ack_o), 1);
        chk("to_data", b1.d_data_o, 32'h0);
        chk("to_err", 32'(b1.err_o), 1);
        chk("to_rd_off", 32'(b1.mem_rd_en_o), 0);
        b1.d_rd_en_i = 0;
        repeat (3) tick();
        chk("to_err_sticky", 32'(b1.err_o), 1);

        // reset during a store
        b0.d_wr_en_i = 1; b0.d_addr_i = 32'h44; b0.d_data_i = 32'h55AA_55AA;
        tick();
        chk("rs_wr", 32'(b0.mem_wr_en_o), 1);
        rst_n = 1'b0;
        tick();
        chk("rs_wr_off", 32'(b0.mem_wr_en_o), 0);
        chk("rs_no_ack", 32'(b0.d_ack_o), 0);
        chk("rs_d_data", b0.d_data_o, 32'h0);
        chk("rs_err_clr", 32'(b1.err_o), 0);
        rst_n = 1'b1;
        tick();
        chk("rs2_wr", 32'(b0.mem_wr_en_o), 1);
        chk("rs2_wdata", b0.mem_data_o, 32'h55AA_55AA);
        tick();
        chk("rs2_ack", 32'(b0.d_ack_o), 1);
        b0.d_wr_en_i = 0;
        tick();
        b0.d_rd_en_i = 1;
        tick();
        tick();
        chk("rs2_ld_ack", 32'(b0.d_ack_o), 1);
        chk("rs2_ld_data", b0.d_data_o, 32'h55AA_55AA);
        b0.d_rd_en_i = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    always @(negedge clk)
        if (rst_n && b0.i_ack_o && b0.d_ack_o) begin
            n_vec++;
            n_bad++;
            $display("FAIL both_acks: got 1 expected 0");
        end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported 32-bit word memory between the processor's instruction-fetch port and its load/store data port.
- Arbitrates round-robin between the two ports and runs one transaction at a time on the memory side.
- Registers each response and returns it to the requester with a one-cycle ack pulse.
- Optional ack timeout with sticky error flag.

Parameters:
- USE_MEM_ACK, 1: 1 = wait for mem_ack_i; 0 = the memory completes in the first ACCESS cycle and mem_ack_i is ignored.
- ACK_TIMEOUT, 16: ACCESS cycles allowed without mem_ack_i before forced completion; must be ≥ 2; used only when USE_MEM_ACK = 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_rd_en_i  in  1  fetch request
- i_addr_i  in  32  fetch byte address
- i_data_o  out  32  fetched word
- i_ack_o  out  1  fetch done, 1-cycle pulse
- d_rd_en_i  in  1  load request
- d_wr_en_i  in  1  store request
- d_addr_i  in  32  load/store byte address
- d_data_i  in  32  store data
- d_data_o  out  32  loaded word
- d_ack_o  out  1  load/store done, 1-cycle pulse
- mem_rd_en_o  out  1  memory read enable
- mem_wr_en_o  out  1  memory write enable
- mem_addr_o  out  32  memory address, passed unmodified
- mem_data_o  out  32  memory write data
- mem_data_i  in  32  memory read data
- mem_ack_i  in  1  memory completion
- err_o  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: state = IDLE; all mem_* outputs, i_data_o, d_data_o, both acks and err_o = 0; timeout counter = 0; last_grant = DATA, so the instruction port wins the first tie.
- Requester rules:
  - Hold the enable(s), address and data stable until the ack pulse.
  - Drop the request in the cycle after the ack.
  - A request still high in IDLE after RESP is a new transaction.
- Data port with d_rd_en_i and d_wr_en_i both high: treated as a write.
- IDLE:
  - Requests are sampled each cycle.
  - Only one port requesting: grant it.
  - Both requesting: grant the port that is not last_grant.
  - On grant: latch port id, operation, address and write data into registers, update last_grant, clear the counter, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - mem_rd_en_o / mem_wr_en_o, mem_addr_o and mem_data_o are driven from the latched registers.
  - Completion occurs when mem_ack_i = 1, or in the first ACCESS cycle if USE_MEM_ACK = 0.
  - On a completed read, capture mem_data_i into the granted port's data_o register at that edge.
  - On a write, data_o is unchanged.
  - Then go to RESP.
  - If USE_MEM_ACK = 1 and the counter reaches ACK_TIMEOUT-1 without ack: set err_o, load 32'h0 into a read port's data_o, go to RESP.
  - The counter increments every ACCESS cycle.
- RESP:
  - The granted port's ack_o = 1 for exactly this cycle; mem enables = 0.
  - Next state is IDLE unconditionally.
- Outside ACCESS: mem_rd_en_o = mem_wr_en_o = 0, mem_addr_o = 0, mem_data_o = 0.
- Data outputs: i_data_o / d_data_o hold their value until the next read completion on that port.
- Latency: with USE_MEM_ACK = 0, request seen in IDLE at cycle n gives ACCESS at n+1 and ack at n+2, i.e. 3 cycles per transaction. With ack after k ACCESS cycles, ack comes at n+1+k.
- Acks: i_ack_o and d_ack_o are never high in the same cycle.
- Non-granted port: its request is held off with no side effects.
- Reset mid-transaction: next edge returns everything to reset values; the in-flight access is abandoned and no ack is issued. err_o is cleared only by reset.

Test Plan:
- Fetch only, USE_MEM_ACK = 0, i_addr_i = 0x8, memory word 2 = 0x00500093 -> mem_rd_en_o high one cycle with mem_addr_o = 0x8; i_ack_o pulses 2 cycles after request; i_data_o = 0x00500093.
- Store then load on data port, addr 0x40, data 0xCAFEBABE -> mem_wr_en_o pulse with mem_data_o = 0xCAFEBABE; d_ack_o pulse; subsequent load gives d_data_o = 0xCAFEBABE; i_ack_o stays 0.
- Both ports request continuously from reset -> grants alternate I, D, I, D; acks alternate one every 3 cycles; no cycle has both acks high.
- USE_MEM_ACK = 1, mem_ack_i asserted on 3rd ACCESS cycle -> mem_rd_en_o high 3 cycles; ack one cycle later; err_o = 0.
- USE_MEM_ACK = 1, ACK_TIMEOUT = 4, mem_ack_i tied 0, load -> ACCESS lasts 4 cycles; d_ack_o pulses; d_data_o = 0; err_o = 1 and stays 1 until rst_n low.
- rst_n low during ACCESS of a store -> next edge mem_wr_en_o = 0, no d_ack_o; after release, re-issued store completes normally.
